// File: rtl/logic_gate_pipe_if.sv
// Handshake bundle for logic_gate_pipe: producer-side request (in_*, op, a, b)
// and consumer-side response (out_*, y, zero) plus the transaction counter.
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic [CNT_W-1:0] txn_count;

  // Environment side: produces transactions and consumes results.
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, zero, txn_count
  );

  // Block side.
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, zero, txn_count
  );
endinterface

// File: rtl/logic_gate_pipe.sv
// Registered eight-function bitwise logic stage with valid/ready on both sides.
// Results (with their zero flag) are computed at the input and held in a
// two-entry buffer: a main slot that drives y/zero and a skid slot that
// absorbs the one-cycle lag of in_ready, which is purely registered.
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  logic_gate_pipe_if.slave    bus
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_main_y;
  logic             r_main_z;
  logic [WIDTH-1:0] r_skid_y;
  logic             r_skid_z;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_res;
  logic             w_res_z;
  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_load_main;
  logic             w_main_from_skid;
  logic             w_load_skid;

  // Handshake outputs depend only on registered state (and rst for in_ready).
  assign bus.in_ready  = !rst && (r_state != S_FULL);
  assign bus.out_valid = (r_state != S_EMPTY);
  assign bus.y         = r_main_y;
  assign bus.zero      = r_main_z;
  assign bus.txn_count = r_cnt;

  assign w_in_hs  = bus.in_valid  && bus.in_ready;
  assign w_out_hs = bus.out_valid && bus.out_ready;

  // Bitwise function select; zero flag travels with the result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    w_res = '0;
    unique case (op_e'(bus.op))
      OP_NOT:  w_res = ~bus.a;
      OP_AND:  w_res = bus.a & bus.b;
      OP_OR:   w_res = bus.a | bus.b;
      OP_XOR:  w_res = bus.a ^ bus.b;
      OP_NAND: w_res = ~(bus.a & bus.b);
      OP_NOR:  w_res = ~(bus.a | bus.b);
      OP_XNOR: w_res = ~(bus.a ^ bus.b);
      OP_BUF:  w_res = bus.a;
    endcase
  end

  assign w_res_z = (w_res == '0);

  // Occupancy FSM: next state and slot load controls.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_in_hs) begin
          w_state_nxt = S_ONE;
          w_load_main = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in_hs && w_out_hs) begin
          // Old result leaves, new one takes its place; occupancy unchanged.
          w_load_main = 1'b1;
        end else if (w_in_hs) begin
          w_state_nxt = S_FULL;
          w_load_skid = 1'b1;
        end else if (w_out_hs) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so only the output side can move.
        if (w_out_hs) begin
          w_state_nxt      = S_ONE;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Main slot: visible on y/zero, so it is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_y <= '0;
      r_main_z <= 1'b0;
    end else if (w_load_main) begin
      r_main_y <= w_res;
      r_main_z <= w_res_z;
    end else if (w_main_from_skid) begin
      r_main_y <= r_skid_y;
      r_main_z <= r_skid_z;
    end
  end

  // Skid slot: loaded when a second result arrives while main is stalled.
  always_ff @(posedge clk) begin
    // NOTE: skid data is not reset; it is never observed unless the FSM
    // (which is reset) has marked it valid, so a reset would only cost gates.
    if (w_load_skid) begin
      r_skid_y <= w_res;
      r_skid_z <= w_res_z;
    end
  end

  // Completed-transaction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst)           r_cnt <= '0;
    else if (w_out_hs) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Presented result must not change while the consumer stalls.
  a_stable_when_stalled : assert property (
    @(posedge clk) disable iff (rst)
      (bus.out_valid && !bus.out_ready) |=> ($stable(bus.y) && $stable(bus.zero))
  );

  // No input may be accepted while both slots are occupied.
  a_no_accept_when_full : assert property (
    @(posedge clk) disable iff (rst)
      (r_state == S_FULL) |-> !bus.in_ready
  );

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: the driver pushes hand-computed
// results when an input handshake is seen; monitors pop and compare on every
// output handshake. A second instance with CNT_W = 4 exercises counter wrap.
module tb_logic_gate_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic_gate_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();
  logic_gate_pipe_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

  logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  typedef struct {
    logic [7:0] y;
    logic       z;
    int         acc;
    bit         lat1;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Drive one transaction starting just after a rising edge; push the expected
  // result at the falling edge preceding the accepting edge.
  task automatic send(input logic [2:0] op_i, input logic [7:0] a_i,
                      input logic [7:0] b_i, input logic [7:0] exp_y, input bit lat1);
    exp_t e;
    int   budget;
    bit   done;
    bus.in_valid = 1'b1;
    bus.op       = op_i;
    bus.a        = a_i;
    bus.b        = b_i;
    budget = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.y    = exp_y;
        e.z    = (exp_y == 8'h00);
        e.acc  = cyc;
        e.lat1 = lat1;
        sb_q.push_back(e);
        done = 1'b1;
      end else if (budget >= 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", budget);
        done = 1'b1;
      end
      budget++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 100) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", sb_q.size());
    end
  endtask

  // Monitor for the main instance: scoreboard, counter model, stall stability.
  logic [15:0] exp_cnt = '0;
  initial begin : mon_main
    exp_t       e;
    bit         prev_stall;
    logic [7:0] prev_y;
    logic       prev_z;
    prev_stall = 1'b0;
    prev_y     = '0;
    prev_z     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_cnt    = '0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && bus.out_valid) begin
          check("stall_y_stable", 32'(bus.y), 32'(prev_y));
          check("stall_z_stable", 32'(bus.zero), 32'(prev_z));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: y=0x%0h with no pending result", bus.y);
          end else begin
            e = sb_q.pop_front();
            check("y", 32'(bus.y), 32'(e.y));
            check("zero", 32'(bus.zero), 32'(e.z));
            check("txn_count", 32'(bus.txn_count), 32'(exp_cnt));
            if (e.lat1) check("latency", 32'(cyc - e.acc), 32'd1);
          end
          exp_cnt++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_y     = bus.y;
        prev_z     = bus.zero;
      end
    end
  end

  // Monitor for the CNT_W = 4 instance: 4-bit wrapping counter model.
  logic [3:0] exp4 = '0;
  initial begin : mon_wrap
    forever begin
      @(negedge clk);
      if (rst) exp4 = '0;
      else if (bus4.out_valid && bus4.out_ready) begin
        check("txn_count_w4", 32'(bus4.txn_count), 32'(exp4));
        exp4++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] sweep_exp [8];
    int         n;
    int         budget;
    sweep_exp = '{8'h5A, 8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'hA5};

    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = 3'd0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0;
    bus4.op       = 3'd7;
    bus4.a        = 8'h00;
    bus4.b        = 8'h00;
    bus4.out_ready = 1'b1;

    // Reset held for 3 cycles with in_valid high.
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_txn_count", 32'(bus.txn_count), 32'd0);
    end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Opcode sweep, back-to-back with out_ready held high.
    for (int i = 0; i < 8; i++) send(3'(i), 8'hA5, 8'h3C, sweep_exp[i], 1'b1);
    wait_drain();
    check("sweep_txn_count", 32'(bus.txn_count), 32'd8);

    // Zero flag.
    send(3'd3, 8'hFF, 8'hFF, 8'h00, 1'b1);
    send(3'd0, 8'hFF, 8'h00, 8'h00, 1'b1);
    wait_drain();
    check("zero_txn_count", 32'(bus.txn_count), 32'd10);

    // Back-pressure: two accepted, third held until the first drains.
    bus.out_ready = 1'b0;
    send(3'd1, 8'hF0, 8'h3C, 8'h30, 1'b0);
    send(3'd2, 8'h0F, 8'h30, 8'h3F, 1'b0);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    fork
      send(3'd6, 8'h12, 8'h34, 8'hD9, 1'b0);
      begin
        @(negedge clk);
        check("bp_full_hold", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_no_comb_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("bp_in_ready_rise", 32'(bus.in_ready), 32'd1);
      end
    join
    wait_drain();
    check("bp_txn_count", 32'(bus.txn_count), 32'd13);

    // Counter wrap on the CNT_W = 4 instance: 17 handshakes.
    bus4.in_valid = 1'b1;
    n      = 0;
    budget = 0;
    while (n < 17 && budget < 100) begin
      @(negedge clk);
      if (bus4.in_ready) n++;
      budget++;
      @(posedge clk);
      #1;
    end
    bus4.in_valid = 1'b0;
    check("wrap_accepted", 32'(n), 32'd17);
    repeat (3) @(posedge clk);
    #1;
    check("wrap_final", 32'(bus4.txn_count), 32'd1);

    // Reset mid-operation with both slots occupied.
    bus.out_ready = 1'b0;
    send(3'd1, 8'hFF, 8'h0F, 8'h0F, 1'b0);
    send(3'd5, 8'h00, 8'h00, 8'hFF, 1'b0);
    check("pre_rst_full", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_txn_count", 32'(bus.txn_count), 32'd0);
    @(negedge clk);
    check("mid_rst_in_ready_up", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("flushed_out_valid", 32'(bus.out_valid), 32'd0);
    end

    // Traffic still flows correctly after the mid-run reset.
    @(posedge clk);
    #1;
    send(3'd4, 8'hF0, 8'hFF, 8'h0F, 1'b1);
    wait_drain();
    check("post_flush_txn_count", 32'(bus.txn_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_gate_pipe.md
# logic_gate_pipe

Parametrised, registered multi-function logic gate stage with a valid/ready handshake on both sides. Applies one of eight bitwise operations (NOT, AND, OR, XOR, NAND, NOR, XNOR, BUF) to two WIDTH-bit operands selected per transaction. It is the pipelined, multi-bit successor to the single-bit combinational gates in `logic_gates/`. It sits between a producer and a consumer that can stall, buffers up to two results, and counts completed transactions.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 16, width of the completed-transaction counter (≥1)

- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer presents a transaction
- in_ready  output  1  block can accept; handshake when in_valid && in_ready
- op  input  3  operation code, sampled on input handshake
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored for NOT and BUF)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts; handshake when out_valid && out_ready
- y  output  WIDTH  result
- zero  output  1  y == 0 for the presented result
- txn_count  output  CNT_W  number of output handshakes since reset

## Operation
- Opcodes, bitwise across all WIDTH bits:
  - 0: NOT a
  - 1: a AND b
  - 2: a OR b
  - 3: a XOR b
  - 4: NAND
  - 5: NOR
  - 6: XNOR
  - 7: BUF a
- All 8 codes are legal; there is no error path.
- Result and zero flag are computed at the input and stored together in two slots, main (drives y/zero) and skid.
- State machine, states EMPTY / ONE / FULL:
  - EMPTY: input handshake → ONE (main loaded).
  - ONE: input handshake and output handshake → ONE (main reloaded with new result).
  - ONE: input handshake only → FULL (skid loaded).
  - ONE: output handshake only → EMPTY.
  - FULL: output handshake → ONE (main ← skid). No input is accepted in FULL.
- out_valid = (state != EMPTY). in_ready = !rst && (state != FULL).
- Results leave in strict acceptance order; none is dropped or duplicated.
- txn_count increments by 1 on every output handshake and wraps from 2^CNT_W−1 to 0.
- y and zero hold stable while out_valid && !out_ready.
- op, a and b are don't-care when no input handshake occurs.

## Timing
- Reset while rst is high:
  - state = EMPTY
  - out_valid = 0, y = 0, zero = 0, txn_count = 0, in_ready = 0
  - Any transaction in flight, including buffered results, is discarded.
- in_ready is 1 in the first cycle after rst deasserts.
- Latency: a result accepted at edge N appears with out_valid = 1 after edge N (one cycle) when the block is EMPTY or draining.
- Throughput: one transaction per cycle while out_ready is held high.
- in_ready depends only on registered state and rst. It has no combinational path from out_ready; the skid slot absorbs the one-cycle lag.
- Simultaneous input and output handshake in ONE: the old main result leaves and the new one enters in the same edge; occupancy is unchanged.
- Back-pressure:
  - After out_ready drops, at most two results are held.
  - in_ready falls the cycle after the second result is accepted.
  - in_ready rises the cycle after the first output handshake from FULL.
- txn_count updates on the same edge as the output handshake.

## Test plan
- Reset and idle: assert rst 3 cycles with in_valid = 1 → out_valid = 0, in_ready = 0, txn_count = 0. After release, in_ready = 1 next cycle and out_valid stays 0 until a handshake.
- Opcode sweep (WIDTH = 8, out_ready = 1): a = 0xA5, b = 0x3C, op 0..7 back-to-back → y = 0x5A, 0x24, 0xBD, 0x99, 0xDB, 0x42, 0x66, 0xA5 on consecutive cycles, one cycle after each input. zero = 0 throughout. txn_count ends at 8.
- Zero flag: op = 3, a = b = 0xFF → y = 0x00, zero = 1. Then op = 0, a = 0xFF → y = 0x00, zero = 1.
- Back-pressure: out_ready = 0, push three transactions → first two accepted, in_ready = 0 from the cycle after the second, third held. Raise out_ready → results emerge in order. The third is accepted one cycle after the first output handshake. No loss.
- Counter wrap: CNT_W = 4, 17 output handshakes → txn_count goes 15 → 0 → 1.
- Reset mid-operation: with the block FULL and out_ready = 0, pulse rst for 1 cycle → out_valid = 0 and txn_count = 0 next cycle. Buffered results never appear. in_ready = 1 the following cycle.
